// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial bus slave: FSM states, transfer direction
// and framing constants, plus a small elaboration-time helper.
package serial_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_ID,
    HDR_ADDR,
    HDR_LEN,
    WR_DATA,
    RD_WAIT,
    RD_SHIFT,
    SKIP
  } state_t;

  localparam logic RD        = 1'b0;
  localparam logic WR        = 1'b1;
  localparam logic START_BIT = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Parametric shift register with parallel load, MSB-first shift and a count of
// bits shifted since the last load/clear.
module serial_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data,
  output logic             serial_out,
  output logic [CNT_W-1:0] count
);

  // Clearing only resets the bit count so a field's final bit can still be
  // shifted in on the same edge that closes the field.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data  <= '0;
      count <= '0;
    end else begin
      if (load) begin
        data <= load_data;
      end else if (shift) begin
        data <= {data[WIDTH-2:0], serial_in};
      end
      if (clear || load) begin
        count <= '0;
      end else if (shift) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign serial_out = data[WIDTH-1];

endmodule

// File: rtl/serial_slave_burst.sv
// Serial-bus slave: decodes a start/ID/address/length header, then either
// writes a burst into local memory or reads one back onto the shared line.
module serial_slave_burst
  import serial_bus_pkg::*;
#(
  parameter int                  ID_WIDTH      = 2,
  parameter logic [ID_WIDTH-1:0] SELF_ID       = 2'b11,
  parameter int                  ADDRESS_WIDTH = 15,
  parameter int                  DATA_WIDTH    = 8,
  parameter int                  BURST_WIDTH   = 4,
  parameter int                  TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rd_wrt,
  input  logic                     bus_util,
  input  logic                     module_dv,
  input  logic [DATA_WIDTH-1:0]    data_in_parellel,
  inout  wire                      data_bus_serial,
  inout  wire                      slave_busy,
  output logic                     write_en_internal,
  output logic                     rd_en_internal,
  output logic [DATA_WIDTH-1:0]    data_out_parellel,
  output logic [ADDRESS_WIDTH-1:0] addr_out,
  output logic                     timeout_err
);

  localparam int RX_W  = max_int(max_int(ADDRESS_WIDTH, DATA_WIDTH),
                                 max_int(ID_WIDTH, BURST_WIDTH));
  localparam int RX_CW = $clog2(RX_W + 1);
  localparam int TX_CW = $clog2(DATA_WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t                   state_reg, state_next;
  logic                     dir_reg, dir_next;
  logic [BURST_WIDTH-1:0]   words_reg, words_next;
  logic [TMO_W-1:0]         tmo_reg, tmo_next;
  logic [ADDRESS_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0]    data_next;
  logic                     wr_en_next;
  logic                     rd_en_next;

  logic                     sample_bit;
  logic                     rx_clear, rx_shift;
  logic [RX_W-1:0]          rx_data;
  logic [RX_W-1:0]          rx_next;
  logic                     rx_serial_out;
  logic [RX_CW-1:0]         rx_count;
  logic                     tx_clear, tx_load, tx_shift;
  logic [DATA_WIDTH-1:0]    tx_data;
  logic                     tx_serial_out;
  logic [TX_CW-1:0]         tx_count;
  logic                     unused_bits;

  assign sample_bit = data_bus_serial;
  // Value of the field in progress including the bit sampled on this edge.
  assign rx_next    = {rx_data[RX_W-2:0], sample_bit};

  serial_shift_reg #(.WIDTH(RX_W)) rx_sr (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (rx_clear),
    .load       (1'b0),
    .load_data  ('0),
    .shift      (rx_shift),
    .serial_in  (sample_bit),
    .data       (rx_data),
    .serial_out (rx_serial_out),
    .count      (rx_count)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) tx_sr (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (tx_clear),
    .load       (tx_load),
    .load_data  (data_in_parellel),
    .shift      (tx_shift),
    .serial_in  (1'b0),
    .data       (tx_data),
    .serial_out (tx_serial_out),
    .count      (tx_count)
  );

  assign unused_bits = ^{rx_serial_out, rx_data[RX_W-1], tx_data};

  // Lines are decoded straight from the state so reset releases them at once.
  assign data_bus_serial = (state_reg == RD_SHIFT) ? tx_serial_out : 1'bz;
  assign slave_busy      = (state_reg == RD_WAIT)  ? 1'b1 : 1'bz;

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    words_next  = words_reg;
    tmo_next    = tmo_reg;
    addr_next   = addr_out;
    data_next   = data_out_parellel;
    wr_en_next  = 1'b0;
    rd_en_next  = 1'b0;
    rx_clear    = 1'b0;
    rx_shift    = 1'b0;
    tx_clear    = 1'b0;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    timeout_err = 1'b0;

    // A completed write always advances the address, even if the bus drops.
    if (write_en_internal) begin
      addr_next = addr_out + ADDRESS_WIDTH'(1);
    end

    if (state_reg != IDLE && !bus_util) begin
      state_next = IDLE;
      rx_clear   = 1'b1;
      tx_clear   = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          rx_clear = 1'b1;
          if (bus_util && sample_bit == START_BIT) begin
            dir_next   = rd_wrt;
            state_next = HDR_ID;
          end
        end
        HDR_ID: begin
          rx_shift = 1'b1;
          if (rx_count == RX_CW'(ID_WIDTH - 1)) begin
            rx_clear   = 1'b1;
            state_next = (rx_next[ID_WIDTH-1:0] == SELF_ID) ? HDR_ADDR : SKIP;
          end
        end
        HDR_ADDR: begin
          rx_shift = 1'b1;
          if (rx_count == RX_CW'(ADDRESS_WIDTH - 1)) begin
            rx_clear   = 1'b1;
            addr_next  = rx_next[ADDRESS_WIDTH-1:0];
            state_next = HDR_LEN;
          end
        end
        HDR_LEN: begin
          rx_shift = 1'b1;
          if (rx_count == RX_CW'(BURST_WIDTH - 1)) begin
            rx_clear   = 1'b1;
            words_next = rx_next[BURST_WIDTH-1:0];
            if (dir_reg == WR) begin
              state_next = WR_DATA;
            end else begin
              state_next = RD_WAIT;
              rd_en_next = 1'b1;
              tmo_next   = '0;
            end
          end
        end
        WR_DATA: begin
          rx_shift = 1'b1;
          if (rx_count == RX_CW'(DATA_WIDTH - 1)) begin
            rx_clear   = 1'b1;
            data_next  = rx_next[DATA_WIDTH-1:0];
            wr_en_next = 1'b1;
            if (words_reg == '0) begin
              state_next = IDLE;
            end else begin
              words_next = words_reg - BURST_WIDTH'(1);
            end
          end
        end
        RD_WAIT: begin
          if (module_dv) begin
            tx_load    = 1'b1;
            state_next = RD_SHIFT;
          end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
            timeout_err = 1'b1;
            state_next  = SKIP;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
        RD_SHIFT: begin
          tx_shift = 1'b1;
          if (tx_count == TX_CW'(DATA_WIDTH - 1)) begin
            tx_clear  = 1'b1;
            addr_next = addr_out + ADDRESS_WIDTH'(1);
            if (words_reg == '0) begin
              state_next = IDLE;
            end else begin
              words_next = words_reg - BURST_WIDTH'(1);
              state_next = RD_WAIT;
              rd_en_next = 1'b1;
              tmo_next   = '0;
            end
          end
        end
        SKIP: begin
          state_next = SKIP;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= IDLE;
      dir_reg           <= RD;
      words_reg         <= '0;
      tmo_reg           <= '0;
      addr_out          <= '0;
      data_out_parellel <= '0;
      write_en_internal <= 1'b0;
      rd_en_internal    <= 1'b0;
    end else begin
      state_reg         <= state_next;
      dir_reg           <= dir_next;
      words_reg         <= words_next;
      tmo_reg           <= tmo_next;
      addr_out          <= addr_next;
      data_out_parellel <= data_next;
      write_en_internal <= wr_en_next;
      rd_en_internal    <= rd_en_next;
    end
  end

endmodule
